// File: rtl/router_pkt_tx_if.sv
// Command, payload and router byte-bus signals of the packet transmitter.
// The slave modport is the transmitter's view; master is the driving side.
interface router_pkt_tx_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_addr;
    logic [5:0] cmd_len;
    logic       cmd_bad_parity;
    logic       cmd_err;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       busy;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_done;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, cmd_bad_parity,
        input  pl_data, pl_valid, busy,
        output cmd_ready, cmd_err, pl_ready, data_out, pkt_valid, tx_done
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_len, cmd_bad_parity,
        output pl_data, pl_valid, busy,
        input  cmd_ready, cmd_err, pl_ready, data_out, pkt_valid, tx_done
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers a whole payload, then sends header,
// payload and XOR parity on the router byte bus, honouring the busy stall.
module router_pkt_tx #(
    parameter int GAP_CYCLES = 2,
    parameter int MAX_LEN    = 63
) (
    input  logic            clock_i,
    input  logic            reset_i,
    router_pkt_tx_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_HEADER  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_PARITY  = 3'd4,
        ST_GAP     = 3'd5
    } state_e;

    localparam logic [6:0] MAX_LEN_C  = 7'(MAX_LEN);
    localparam logic [7:0] GAP_LAST_C = 8'(GAP_CYCLES - 1);

    function automatic logic [7:0] parity_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    function automatic logic [7:0] make_header(input logic [5:0] len, input logic [1:0] addr);
        return {len, addr};
    endfunction

    state_e     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [5:0] len_q, len_d;
    logic       bad_q, bad_d;
    logic [5:0] wr_cnt_q, wr_cnt_d;
    logic [5:0] rd_cnt_q, rd_cnt_d;
    logic [7:0] parity_q, parity_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic [7:0] data_out_q, data_out_d;
    logic       pkt_valid_q, pkt_valid_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic       pl_ready_q, pl_ready_d;
    logic       cmd_err_q, cmd_err_d;
    logic       tx_done_q, tx_done_d;

    logic [7:0] mem_q [MAX_LEN];

    logic       cmd_ok_s;
    logic       mem_we_s;
    logic [5:0] wr_inc_s;
    logic [5:0] rd_inc_s;
    logic [7:0] par_nxt_s;

    assign cmd_ok_s  = (bus.cmd_addr != 2'b11) && (bus.cmd_len != 6'd0) &&
                       ({1'b0, bus.cmd_len} <= MAX_LEN_C);
    assign mem_we_s  = (state_q == ST_LOAD) && bus.pl_valid && pl_ready_q;
    assign wr_inc_s  = wr_cnt_q + 6'd1;
    assign rd_inc_s  = rd_cnt_q + 6'd1;
    assign par_nxt_s = parity_fold(parity_q, data_out_q);

    // Payload buffer write; contents need no reset
    always_ff @(posedge clock_i) begin
        if (mem_we_s) begin
            mem_q[wr_cnt_q] <= bus.pl_data;
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        bad_d       = bad_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        parity_d    = parity_q;
        gap_cnt_d   = gap_cnt_q;
        data_out_d  = data_out_q;
        pkt_valid_d = pkt_valid_q;
        cmd_ready_d = 1'b0;
        pl_ready_d  = 1'b0;
        cmd_err_d   = 1'b0;
        tx_done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                data_out_d  = 8'h00;
                pkt_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    addr_d = bus.cmd_addr;
                    len_d  = bus.cmd_len;
                    bad_d  = bus.cmd_bad_parity;
                    if (cmd_ok_s) begin
                        state_d     = ST_LOAD;
                        wr_cnt_d    = 6'd0;
                        cmd_ready_d = 1'b0;
                        pl_ready_d  = 1'b1;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                data_out_d  = 8'h00;
                pkt_valid_d = 1'b0;
                pl_ready_d  = 1'b1;
                if (mem_we_s) begin
                    wr_cnt_d = wr_inc_s;
                    if (wr_inc_s == len_q) begin
                        state_d     = ST_HEADER;
                        pl_ready_d  = 1'b0;
                        data_out_d  = make_header(len_q, addr_q);
                        pkt_valid_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_HEADER: begin
                if (!bus.busy) begin
                    parity_d    = data_out_q;
                    state_d     = ST_PAYLOAD;
                    rd_cnt_d    = 6'd0;
                    data_out_d  = mem_q[6'd0];
                    pkt_valid_d = 1'b1;
                end else begin
                    state_d = ST_HEADER;
                end
            end
            ST_PAYLOAD: begin
                if (!bus.busy) begin
                    parity_d = par_nxt_s;
                    if (rd_cnt_q == (len_q - 6'd1)) begin
                        state_d     = ST_PARITY;
                        data_out_d  = bad_q ? ~par_nxt_s : par_nxt_s;
                        pkt_valid_d = 1'b0;
                    end else begin
                        rd_cnt_d    = rd_inc_s;
                        data_out_d  = mem_q[rd_inc_s];
                        pkt_valid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PARITY: begin
                if (!bus.busy) begin
                    state_d     = ST_GAP;
                    gap_cnt_d   = 8'd0;
                    tx_done_d   = 1'b1;
                    data_out_d  = 8'h00;
                    pkt_valid_d = 1'b0;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_GAP: begin
                data_out_d  = 8'h00;
                pkt_valid_d = 1'b0;
                if (gap_cnt_q == GAP_LAST_C) begin
                    state_d     = ST_IDLE;
                    cmd_ready_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                data_out_d  = 8'h00;
                pkt_valid_d = 1'b0;
            end
        endcase
    end

    // State, counter and registered-output update with synchronous reset
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= 2'd0;
            len_q       <= 6'd0;
            bad_q       <= 1'b0;
            wr_cnt_q    <= 6'd0;
            rd_cnt_q    <= 6'd0;
            parity_q    <= 8'h00;
            gap_cnt_q   <= 8'd0;
            data_out_q  <= 8'h00;
            pkt_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            pl_ready_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            bad_q       <= bad_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            parity_q    <= parity_d;
            gap_cnt_q   <= gap_cnt_d;
            data_out_q  <= data_out_d;
            pkt_valid_q <= pkt_valid_d;
            cmd_ready_q <= cmd_ready_d;
            pl_ready_q  <= pl_ready_d;
            cmd_err_q   <= cmd_err_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.cmd_err   = cmd_err_q;
    assign bus.pl_ready  = pl_ready_q;
    assign bus.data_out  = data_out_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.tx_done   = tx_done_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: stimulus pushes the expected router bytes,
// a negedge monitor pops and compares every presented byte and tx_done.
module tb_router_pkt_tx;
    logic clock_i = 1'b0;
    logic reset_i = 1'b1;

    router_pkt_tx_if bus ();

    router_pkt_tx #(.GAP_CYCLES(2), .MAX_LEN(63)) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clock_i = ~clock_i;

    int         total = 0;
    int         bad   = 0;
    logic [8:0] exp_q [$];
    bit         in_pkt    = 1'b0;
    bit         done_pend = 1'b0;
    int         pres22    = 0;
    logic [7:0] pl_bytes [64];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected packet: header, payload, then parity with pkt_valid low
    task automatic push_pkt(input logic [1:0] a, input int n, input bit badp);
        logic [7:0] hdr;
        logic [7:0] p;
        hdr = {6'(n), a};
        p   = hdr;
        exp_q.push_back({1'b1, hdr});
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b1, pl_bytes[i]});
            p = p ^ pl_bytes[i];
        end
        exp_q.push_back({1'b0, badp ? ~p : p});
    endtask

    // Monitor: compare every presented byte, consume it when busy is low
    always @(negedge clock_i) begin
        if (reset_i) begin
            in_pkt    = 1'b0;
            done_pend = 1'b0;
            exp_q.delete();
        end else begin
            if (bus.tx_done || done_pend) begin
                check("tx_done", {31'd0, bus.tx_done}, {31'd0, done_pend});
            end
            done_pend = 1'b0;
            if (bus.pkt_valid && (bus.data_out == 8'h22)) begin
                pres22++;
            end
            if (bus.pkt_valid || in_pkt) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got=%0h pkt_valid=%0b expected=none",
                             bus.data_out, bus.pkt_valid);
                end else begin
                    check("router_byte", {23'd0, bus.pkt_valid, bus.data_out}, {23'd0, exp_q[0]});
                    if (!bus.busy) begin
                        void'(exp_q.pop_front());
                        if (bus.pkt_valid) begin
                            in_pkt = 1'b1;
                        end else begin
                            in_pkt    = 1'b0;
                            done_pend = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic send_cmd(input logic [1:0] a, input logic [5:0] n, input bit badp);
        int cnt;
        bus.cmd_addr       = a;
        bus.cmd_len        = n;
        bus.cmd_bad_parity = badp;
        bus.cmd_valid      = 1'b1;
        cnt = 0;
        @(negedge clock_i);
        while (!bus.cmd_ready && cnt < 500) begin
            @(negedge clock_i);
            cnt++;
        end
        if (cnt >= 500) check("cmd_ready_timeout", 32'd0, 32'd1);
        @(posedge clock_i);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_payload(input int n, input bit toggle);
        int cnt;
        for (int i = 0; i < n; i++) begin
            bus.pl_data  = pl_bytes[i];
            bus.pl_valid = 1'b1;
            cnt = 0;
            @(negedge clock_i);
            while (!bus.pl_ready && cnt < 500) begin
                @(negedge clock_i);
                cnt++;
            end
            if (cnt >= 500) check("pl_ready_timeout", 32'd0, 32'd1);
            @(posedge clock_i);
            #1;
            bus.pl_valid = 1'b0;
            if (toggle) begin
                @(posedge clock_i);
                #1;
            end
        end
        @(negedge clock_i);
        check("pl_ready_low_after_load", {31'd0, bus.pl_ready}, 32'd0);
    endtask

    task automatic wait_byte(input logic [7:0] v);
        int cnt;
        cnt = 0;
        do begin
            @(negedge clock_i);
            cnt++;
        end while (!(bus.pkt_valid && bus.data_out == v) && cnt < 500);
        check("wait_byte", {23'd0, bus.pkt_valid, bus.data_out}, {23'd0, 1'b1, v});
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 2000) begin
            @(negedge clock_i);
            cnt++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
        repeat (4) @(negedge clock_i);
        @(posedge clock_i);
        #1;
    endtask

    task automatic load_t1();
        pl_bytes[0] = 8'h11;
        pl_bytes[1] = 8'h22;
        pl_bytes[2] = 8'h33;
    endtask

    initial begin
        int snap;
        bus.cmd_valid = 1'b0; bus.cmd_addr = 2'd0; bus.cmd_len = 6'd0;
        bus.cmd_bad_parity = 1'b0; bus.pl_data = 8'h00; bus.pl_valid = 1'b0;
        bus.busy = 1'b0;

        // Reset state
        repeat (3) @(posedge clock_i);
        @(negedge clock_i);
        check("rst_data_out",  {24'd0, bus.data_out}, 32'd0);
        check("rst_pkt_valid", {31'd0, bus.pkt_valid}, 32'd0);
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        check("rst_pl_ready",  {31'd0, bus.pl_ready}, 32'd0);
        check("rst_cmd_err",   {31'd0, bus.cmd_err}, 32'd0);
        check("rst_tx_done",   {31'd0, bus.tx_done}, 32'd0);
        @(posedge clock_i); #1; reset_i = 1'b0;
        @(negedge clock_i); @(negedge clock_i);
        check("cmd_ready_after_reset", {31'd0, bus.cmd_ready}, 32'd1);
        @(posedge clock_i); #1;

        // 1: basic packet 0D,11,22,33,0D
        load_t1();
        push_pkt(2'd1, 3, 1'b0);
        send_cmd(2'd1, 6'd3, 1'b0);
        send_payload(3, 1'b0);
        drain();

        // 2: busy for 3 cycles while 0x22 is presented
        snap = pres22;
        push_pkt(2'd1, 3, 1'b0);
        send_cmd(2'd1, 6'd3, 1'b0);
        send_payload(3, 1'b0);
        wait_byte(8'h11);
        @(posedge clock_i); #1; bus.busy = 1'b1;
        repeat (3) @(posedge clock_i);
        #1; bus.busy = 1'b0;
        drain();
        check("hold_22_cycles", pres22 - snap, 32'd4);

        // 3: rejected commands (addr 3, then len 0)
        send_cmd(2'd3, 6'd4, 1'b0);
        @(negedge clock_i);
        check("cmd_err_addr3", {31'd0, bus.cmd_err}, 32'd1);
        @(negedge clock_i);
        check("cmd_err_pulse_end", {31'd0, bus.cmd_err}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock_i);
            check("pl_ready_after_err", {31'd0, bus.pl_ready}, 32'd0);
            check("cmd_ready_after_err", {31'd0, bus.cmd_ready}, 32'd1);
        end
        @(posedge clock_i); #1;
        send_cmd(2'd0, 6'd0, 1'b0);
        @(negedge clock_i);
        check("cmd_err_len0", {31'd0, bus.cmd_err}, 32'd1);
        @(posedge clock_i); #1;

        // 4: max length, incrementing payload, gappy pl_valid
        for (int i = 0; i < 63; i++) pl_bytes[i] = 8'(i);
        push_pkt(2'd2, 63, 1'b0);
        send_cmd(2'd2, 6'd63, 1'b0);
        send_payload(63, 1'b1);
        drain();

        // 5: inverted parity (0xF2), parity byte held under busy
        load_t1();
        push_pkt(2'd1, 3, 1'b1);
        send_cmd(2'd1, 6'd3, 1'b1);
        send_payload(3, 1'b0);
        wait_byte(8'h33);
        @(posedge clock_i); #1; bus.busy = 1'b1;
        repeat (2) @(posedge clock_i);
        #1; bus.busy = 1'b0;
        drain();

        // 6: reset during payload byte 2 of a len=10 packet
        for (int i = 0; i < 10; i++) pl_bytes[i] = 8'hA0 + 8'(i);
        push_pkt(2'd0, 10, 1'b0);
        send_cmd(2'd0, 6'd10, 1'b0);
        send_payload(10, 1'b0);
        wait_byte(8'hA1);
        @(posedge clock_i); #1; reset_i = 1'b1;
        @(negedge clock_i);
        @(negedge clock_i);
        check("midrst_pkt_valid", {31'd0, bus.pkt_valid}, 32'd0);
        check("midrst_data_out", {24'd0, bus.data_out}, 32'd0);
        @(posedge clock_i); #1; reset_i = 1'b0;
        @(negedge clock_i); @(negedge clock_i);
        check("midrst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        @(posedge clock_i); #1;
        load_t1();
        push_pkt(2'd1, 3, 1'b0);
        send_cmd(2'd1, 6'd3, 1'b0);
        send_payload(3, 1'b0);
        drain();

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
